serial_dft_bin_engine: RTL and testbench
========================================

# serial_dft_bin_engine

Multi-channel serial single-bin DFT correlator with a runtime-selectable harmonic index and a held result register. It sits in the AC_PH cascade after sample acquisition. Each frame of FRAME_LENGTH valid samples on CHANNELS parallel channels produces one complex bin X[k] per channel. The block generates twiddle addresses modulo FRAME_LENGTH for harmonic k, reads an external synchronous twiddle ROM, and presents results through a valid/ready handshake with overrun detection.

## Interface
- W_WIDTH, 16, signed twiddle width
- X_WIDTH, 16, signed sample width
- S_WIDTH, 40, signed accumulator/result width; must be >= W_WIDTH+X_WIDTH+$clog2(FRAME_LENGTH)
- FRAME_LENGTH, 64, samples per frame, >= 2
- CHANNELS, 2, parallel channels sharing one twiddle stream
- A_WIDTH, $clog2(FRAME_LENGTH), twiddle address and harmonic index width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  sample strobe
- x  in  [CHANELS-1:0][X_WIDTH]  signed samples, packed, channel 0 in LSBs
- k_i  in  A_WIDTH  harmonic index, sampled with the first sample of a frame
- w_addr  out  A_WIDTH  twiddle ROM address, combinational from the phase register
- w_re, w_im  in  W_WIDTH each  twiddle data, returned one cycle after w_addr
- re, im  out  [CHANELS-1:0][S_WIDTH]  held signed results
- k_o  out  A_WIDTH  harmonic index of the held result
- valid_o  out  1  result held and not yet accepted
- ready_i  in  1  consumer accepts the result when valid_o && ready_i
- finish  out  1  one-cycle pulse when a frame result is loaded
- overrun  out  1  one-cycle pulse when a completed frame is dropped
- busy  out  1  a frame is partially received or the pipeline is draining

## Operation
- Sample counter n runs 0..FRAME_LENGTH-1 and advances on each valid_i. It wraps to 0 after the last sample. Frames are back-to-back, with no idle cycle required.
- When valid_i is high and n==0, k_i is latched as the step. If k_i >= FRAME_LENGTH, the latched step is 0.
- Phase register p: 0 at n==0. After each valid sample, p <= (p+step) mod FRAME_LENGTH, computed without a divider (conditional subtract).
- w_addr = p while valid_i (value when valid_i is low: don't care, held at p).
- Pipeline:
  - Stage 1: register x, valid, last flag (n==FRAME_LENGTH-1) and the frame's step.
  - Stage 2: per channel, products x*w_re and x*w_im, full W_WIDTH+X_WIDTH precision, registered.
  - Stage 3: sign-extend products to S_WIDTH and accumulate. The first product of a frame loads the accumulator instead of adding. No saturation; the width rule guarantees no overflow.
- Completion: when the stage-3 last flag is set, the accumulator is transferred to re/im (current product included), k_o <= frame step, finish pulses.
- Output states, HOLD_EMPTY / HOLD_FULL:
  - HOLD_EMPTY + completion -> load, valid_o=1.
  - HOLD_FULL + ready_i, no completion -> valid_o=0.
  - HOLD_FULL + completion + ready_i (same cycle) -> old result accepted, new one loaded, valid_o stays 1, finish=1.
  - HOLD_FULL + completion + !ready_i -> new result discarded, held values unchanged, overrun=1, finish=0.
- busy = (n!=0) || any stage valid.
- rst mid-frame discards partial accumulations. The next valid_i is treated as n=0.

## Timing
- Reset values:
  - re, im, k_o, w_addr(p), n, accumulators, pipeline valids = 0.
  - valid_o, finish, overrun, busy = 0.
- Latency: last sample at edge T -> finish/valid_o high after edge T+3 (re/im valid from the same cycle).
- Throughput: one sample per clock on all channels. Gaps in valid_i are allowed anywhere; they stall n and p but not the pipeline.
- valid_o falls the cycle after acceptance unless reloaded in the same cycle.
- The ROM must return data for the address presented at cycle t at cycle t+1.

## Test plan
Setup for all scenarios: FRAME_LENGTH=4, CHANNELS=2, test ROM w_re={1,0,-1,0}, w_im={0,-1,0,1}, ch0 x=1,3,5,7, ch1 x=2,4,6,8, ready_i=1.
- k_i=1 -> re={-4,-4}, im={4,4}, k_o=1, finish 3 cycles after the 4th sample, w_addr sequence 0,1,2,3.
- k_i=0 -> re={16,20}, im={0,0}; k_i=2 -> w_addr 0,2,0,2, re={-4,-4}, im={0,0}; k_i=5 -> step 0, results as k=0.
- Two back-to-back frames (k=1, then k=2), ready_i=1 -> two finish pulses 4 cycles apart, second result {-4,-4}/{0,0}, k_o=2.
- Same two frames, ready_i=0 throughout -> first result held, overrun pulse 4 cycles after finish, valid_o stays 1. Raising ready_i -> valid_o drops next cycle.
- valid_i gaps of 1-3 cycles between samples, k=1 -> results identical to the gapless case.
- rst asserted after 2 samples, then a full k=1 frame -> no finish from the aborted frame, results {-4,-4}/{4,4}, all outputs 0 during reset.

Source files
------------

// File: rtl/serial_dft_bin_engine.sv
// Multi-channel serial single-bin DFT correlator: per frame, accumulates x[n]*W[(n*k) mod N]
// per channel through a 3-stage pipeline and holds the result behind a valid/ready handshake.
module serial_dft_bin_engine #(
  parameter int unsigned W_WIDTH      = 16,
  parameter int unsigned X_WIDTH      = 16,
  parameter int unsigned S_WIDTH      = 40,
  parameter int unsigned FRAME_LENGTH = 64,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned A_WIDTH      = $clog2(FRAME_LENGTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_i,
  input  logic [CHANNELS-1:0][X_WIDTH-1:0]   x,
  input  logic [A_WIDTH-1:0]                 k_i,
  output logic [A_WIDTH-1:0]                 w_addr,
  input  logic [W_WIDTH-1:0]                 w_re,
  input  logic [W_WIDTH-1:0]                 w_im,
  output logic [CHANNELS-1:0][S_WIDTH-1:0]   re,
  output logic [CHANNELS-1:0][S_WIDTH-1:0]   im,
  output logic [A_WIDTH-1:0]                 k_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               finish,
  output logic                               overrun,
  output logic                               busy
);

  localparam int unsigned        P_WIDTH = W_WIDTH + X_WIDTH;
  localparam logic [A_WIDTH:0]   FL_EXT  = (A_WIDTH+1)'(FRAME_LENGTH);
  localparam logic [A_WIDTH-1:0] LAST_N  = A_WIDTH'(FRAME_LENGTH - 1);

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;

  // Front end: sample counter, harmonic step and twiddle phase
  logic [A_WIDTH-1:0] n_q, n_d, p_q, p_d, step_q, step_d, k_sel;
  logic [A_WIDTH:0]   p_sum, p_red;
  logic               first_c, last_c;

  always_comb begin
    first_c = (n_q == '0);
    last_c  = (n_q == LAST_N);
    k_sel   = ({1'b0, k_i} >= FL_EXT) ? '0 : k_i;
    step_d  = first_c ? k_sel : step_q;
    p_sum   = {1'b0, p_q} + {1'b0, step_d};
    p_red   = (p_sum >= FL_EXT) ? (p_sum - FL_EXT) : p_sum;
    n_d     = last_c ? '0 : (n_q + A_WIDTH'(1));
    p_d     = last_c ? '0 : p_red[A_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q    <= '0;
      p_q    <= '0;
      step_q <= '0;
    end else if (valid_i) begin
      n_q    <= n_d;
      p_q    <= p_d;
      step_q <= step_d;
    end
  end

  assign w_addr = p_q;

  // Stage 1: align samples with the twiddle returned by the ROM one cycle later
  logic [CHANNELS-1:0][X_WIDTH-1:0] x1_q;
  logic                             v1_q, last1_q, first1_q;
  logic [A_WIDTH-1:0]               step1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q     <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      first1_q <= 1'b0;
      step1_q  <= '0;
    end else begin
      x1_q     <= x;
      v1_q     <= valid_i;
      last1_q  <= last_c;
      first1_q <= first_c;
      step1_q  <= step_d;
    end
  end

  // Stage 2: full-precision complex products
  logic signed [P_WIDTH-1:0] pr_d [CHANNELS];
  logic signed [P_WIDTH-1:0] pi_d [CHANNELS];
  logic signed [P_WIDTH-1:0] pr_q [CHANNELS];
  logic signed [P_WIDTH-1:0] pi_q [CHANNELS];
  logic                      v2_q, last2_q, first2_q;
  logic [A_WIDTH-1:0]        step2_q;

  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      pr_d[c] = P_WIDTH'($signed(x1_q[c]) * $signed(w_re));
      pi_d[c] = P_WIDTH'($signed(x1_q[c]) * $signed(w_im));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        pr_q[c] <= '0;
        pi_q[c] <= '0;
      end
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      first2_q <= 1'b0;
      step2_q  <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        pr_q[c] <= pr_d[c];
        pi_q[c] <= pi_d[c];
      end
      v2_q     <= v1_q;
      last2_q  <= last1_q;
      first2_q <= first1_q;
      step2_q  <= step1_q;
    end
  end

  // Stage 3: accumulate; the first product of a frame restarts the sum
  logic signed [S_WIDTH-1:0] acc_re_q [CHANNELS];
  logic signed [S_WIDTH-1:0] acc_im_q [CHANNELS];
  logic                      v3_q, last3_q;
  logic [A_WIDTH-1:0]        step3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        acc_re_q[c] <= '0;
        acc_im_q[c] <= '0;
      end
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      step3_q <= '0;
    end else begin
      if (v2_q) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          acc_re_q[c] <= first2_q ? S_WIDTH'(pr_q[c]) : (acc_re_q[c] + S_WIDTH'(pr_q[c]));
          acc_im_q[c] <= first2_q ? S_WIDTH'(pi_q[c]) : (acc_im_q[c] + S_WIDTH'(pi_q[c]));
        end
      end
      v3_q    <= v2_q;
      last3_q <= v2_q && last2_q;
      step3_q <= step2_q;
    end
  end

  // Result hold register with valid/ready handshake and overrun detection
  hold_e                            hold_q, hold_d;
  logic                             done_c, load_c, finish_d, overrun_d;
  logic                             finish_q, overrun_q;
  logic [CHANNELS-1:0][S_WIDTH-1:0] re_q, im_q;
  logic [A_WIDTH-1:0]               k_q;

  assign done_c = v3_q && last3_q;

  always_comb begin
    hold_d    = hold_q;
    load_c    = 1'b0;
    finish_d  = 1'b0;
    overrun_d = 1'b0;
    case (hold_q)
      HOLD_EMPTY: begin
        if (done_c) begin
          load_c   = 1'b1;
          finish_d = 1'b1;
          hold_d   = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (done_c && ready_i) begin
          load_c   = 1'b1;
          finish_d = 1'b1;
        end else if (done_c) begin
          overrun_d = 1'b1;
        end else if (ready_i) begin
          hold_d = HOLD_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= HOLD_EMPTY;
      finish_q  <= 1'b0;
      overrun_q <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      k_q       <= '0;
    end else begin
      hold_q    <= hold_d;
      finish_q  <= finish_d;
      overrun_q <= overrun_d;
      if (load_c) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          re_q[c] <= acc_re_q[c];
          im_q[c] <= acc_im_q[c];
        end
        k_q <= step3_q;
      end
    end
  end

  assign re      = re_q;
  assign im      = im_q;
  assign k_o     = k_q;
  assign valid_o = (hold_q == HOLD_FULL);
  assign finish  = finish_q;
  assign overrun = overrun_q;
  assign busy    = (n_q != '0) || v1_q || v2_q || v3_q;

endmodule

// File: tb/tb_serial_dft_bin_engine.sv
// Bench for serial_dft_bin_engine: directed frames on a small test ROM plus randomized
// frames checked against a direct DFT-sum reference model.
module tb_serial_dft_bin_engine;

  localparam int N  = 4;
  localparam int C  = 2;
  localparam int XW = 16;
  localparam int WW = 16;
  localparam int SW = 40;
  localparam int AW = 3;

  logic                   clk = 1'b0;
  logic                   rst, valid_i, ready_i;
  logic [C-1:0][XW-1:0]   x;
  logic [AW-1:0]          k_i, w_addr, k_o;
  logic [WW-1:0]          w_re, w_im;
  logic [C-1:0][SW-1:0]   re, im;
  logic                   valid_o, finish, overrun, busy;

  serial_dft_bin_engine #(
    .W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW), .FRAME_LENGTH(N), .CHANNELS(C), .A_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .x(x), .k_i(k_i), .w_addr(w_addr),
    .w_re(w_re), .w_im(w_im), .re(re), .im(im), .k_o(k_o), .valid_o(valid_o),
    .ready_i(ready_i), .finish(finish), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous twiddle ROM, one-cycle read latency
  int rom_re[N];
  int rom_im[N];
  always @(posedge clk) begin
    w_re <= WW'(rom_re[int'(w_addr) % N]);
    w_im <= WW'(rom_im[int'(w_addr) % N]);
  end

  typedef struct {
    int     cyc;
    longint re0, re1, im0, im1;
    int     k;
  } res_t;

  res_t res_q[$];
  res_t exp_q[$];
  int   ovr_q[$];
  int   waddr_q[$];
  res_t mon_r;

  always @(negedge clk) begin
    if (finish === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.re0 = longint'($signed(re[0]));
      mon_r.re1 = longint'($signed(re[1]));
      mon_r.im0 = longint'($signed(im[0]));
      mon_r.im1 = longint'($signed(im[1]));
      mon_r.k   = int'(k_o);
      res_q.push_back(mon_r);
    end
    if (overrun === 1'b1) ovr_q.push_back(cyc);
  end

  int fx0[N];
  int fx1[N];
  int last_edge;
  int vectors = 0;
  int errors  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_plan();
    rom_re = '{1, 0, -1, 0};
    rom_im = '{0, -1, 0, 1};
    fx0    = '{1, 3, 5, 7};
    fx1    = '{2, 4, 6, 8};
  endtask

  task automatic send_frame(input int k, input int gmin, input int gmax);
    for (int n = 0; n < N; n++) begin
      if (n > 0) begin
        int g;
        g = int'($urandom_range(gmax, gmin));
        for (int i = 0; i < g; i++) begin
          valid_i = 1'b0;
          x       = (C*XW)'($urandom);
          k_i     = AW'($urandom);
          tick();
        end
      end
      valid_i = 1'b1;
      x[0]    = XW'(fx0[n]);
      x[1]    = XW'(fx1[n]);
      k_i     = (n == 0) ? AW'(k) : AW'($urandom);
      #1 waddr_q.push_back(int'(w_addr));
      @(posedge clk);
      #1;
      last_edge = cyc;
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_results(input int cnt, input int budget);
    for (int i = 0; i < budget && res_q.size() < cnt; i++) tick();
  endtask

  // Reference: direct DFT bin sum with step = k, or 0 when k is out of range
  function automatic longint model(input int ch, input int k, input bit is_im);
    int     step;
    longint s;
    step = (k >= N) ? 0 : k;
    s = 0;
    for (int n = 0; n < N; n++) begin
      int idx;
      idx = (n * step) % N;
      s += longint'((ch == 0) ? fx0[n] : fx1[n]) * longint'(is_im ? rom_im[idx] : rom_re[idx]);
    end
    return s;
  endfunction

  function automatic res_t expect_for(input int k);
    res_t e;
    e.cyc = 0;
    e.re0 = model(0, k, 1'b0);
    e.re1 = model(1, k, 1'b0);
    e.im0 = model(0, k, 1'b1);
    e.im1 = model(1, k, 1'b1);
    e.k   = (k >= N) ? 0 : k;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; x = '0; k_i = '0;
    repeat (3) tick();
    vectors++;
    if ({re, im} !== '0 || k_o !== '0 || w_addr !== '0) begin
      errors++;
      $display("FAIL reset_data re=%h im=%h k_o=%0d w_addr=%0d want all 0", re, im, k_o, w_addr);
    end
    vectors++;
    if ({valid_o, finish, overrun, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags valid/finish/overrun/busy=%b want 0000", {valid_o, finish, overrun, busy});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_k1();
    res_t r;
    load_plan();
    res_q.delete(); waddr_q.delete();
    send_frame(1, 0, 0);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL k1_busy got %b want 1", busy); end
    wait_results(1, 10);
    vectors++;
    if (res_q.size() != 1) begin
      errors++; $display("FAIL k1_count got %0d want 1", res_q.size());
    end else begin
      r = res_q[0];
      vectors++;
      if (r.re0 != -4 || r.re1 != -4 || r.im0 != 4 || r.im1 != 4 || r.k != 1) begin
        errors++;
        $display("FAIL k1_result got re=%0d,%0d im=%0d,%0d k=%0d want -4,-4 4,4 k=1",
                 r.re0, r.re1, r.im0, r.im1, r.k);
      end
      vectors++;
      if (r.cyc - last_edge != 3) begin
        errors++; $display("FAIL k1_latency got %0d want 3", r.cyc - last_edge);
      end
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (waddr_q[i] != i) begin
        errors++; $display("FAIL k1_waddr[%0d] got %0d want %0d", i, waddr_q[i], i);
      end
    end
    repeat (3) tick();
    vectors++;
    if ({busy, valid_o} !== 2'b00) begin
      errors++; $display("FAIL k1_idle busy/valid_o=%b want 00", {busy, valid_o});
    end
  endtask

  task automatic test_k_values();
    int     ks[3]  = '{0, 2, 5};
    longint er0[3] = '{16, -4, 16};
    longint er1[3] = '{20, -4, 20};
    int     ek[3]  = '{0, 2, 0};
    res_t   r;
    load_plan();
    for (int t = 0; t < 3; t++) begin
      res_q.delete(); waddr_q.delete();
      send_frame(ks[t], 0, 0);
      wait_results(1, 10);
      vectors++;
      if (res_q.size() != 1) begin
        errors++; $display("FAIL kval%0d_count got %0d want 1", ks[t], res_q.size());
      end else begin
        r = res_q[0];
        if (r.re0 != er0[t] || r.re1 != er1[t] || r.im0 != 0 || r.im1 != 0 || r.k != ek[t]) begin
          errors++;
          $display("FAIL kval%0d_result got re=%0d,%0d im=%0d,%0d k=%0d want %0d,%0d 0,0 k=%0d",
                   ks[t], r.re0, r.re1, r.im0, r.im1, r.k, er0[t], er1[t], ek[t]);
        end
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (waddr_q[i] != (i * ek[t]) % N) begin
          errors++;
          $display("FAIL kval%0d_waddr[%0d] got %0d want %0d", ks[t], i, waddr_q[i], (i * ek[t]) % N);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    load_plan();
    res_q.delete();
    send_frame(1, 0, 0);
    send_frame(2, 0, 0);
    wait_results(2, 12);
    vectors++;
    if (res_q.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", res_q.size());
    end else begin
      vectors++;
      if (res_q[1].cyc - res_q[0].cyc != 4 || res_q[1].cyc - last_edge != 3) begin
        errors++;
        $display("FAIL b2b_spacing got gap=%0d lat=%0d want 4 and 3",
                 res_q[1].cyc - res_q[0].cyc, res_q[1].cyc - last_edge);
      end
      vectors++;
      if (res_q[0].k != 1 || res_q[1].re0 != -4 || res_q[1].re1 != -4 ||
          res_q[1].im0 != 0 || res_q[1].im1 != 0 || res_q[1].k != 2) begin
        errors++;
        $display("FAIL b2b_result got k0=%0d re=%0d,%0d im=%0d,%0d k1=%0d want 1 -4,-4 0,0 2",
                 res_q[0].k, res_q[1].re0, res_q[1].re1, res_q[1].im0, res_q[1].im1, res_q[1].k);
      end
    end
    tick();
  endtask

  task automatic test_overrun();
    load_plan();
    res_q.delete(); ovr_q.delete();
    ready_i = 1'b0;
    send_frame(1, 0, 0);
    send_frame(2, 0, 0);
    repeat (6) tick();
    vectors++;
    if (res_q.size() != 1 || ovr_q.size() != 1) begin
      errors++;
      $display("FAIL ovr_counts got finish=%0d overrun=%0d want 1 and 1", res_q.size(), ovr_q.size());
    end else begin
      vectors++;
      if (ovr_q[0] - res_q[0].cyc != 4) begin
        errors++; $display("FAIL ovr_spacing got %0d want 4", ovr_q[0] - res_q[0].cyc);
      end
    end
    vectors++;
    if (valid_o !== 1'b1 || $signed(re[0]) != -4 || $signed(re[1]) != -4 ||
        $signed(im[0]) != 4 || $signed(im[1]) != 4 || k_o !== AW'(1)) begin
      errors++;
      $display("FAIL ovr_held got valid_o=%b re0=%0d im0=%0d k_o=%0d want 1 -4 4 1",
               valid_o, $signed(re[0]), $signed(im[0]), k_o);
    end
    ready_i = 1'b1;
    tick();
    vectors++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_accept valid_o got %b want 0", valid_o); end
  endtask

  task automatic test_gaps();
    res_t r;
    load_plan();
    res_q.delete(); waddr_q.delete();
    send_frame(1, 1, 3);
    wait_results(1, 10);
    vectors++;
    if (res_q.size() != 1) begin
      errors++; $display("FAIL gaps_count got %0d want 1", res_q.size());
    end else begin
      r = res_q[0];
      vectors++;
      if (r.re0 != -4 || r.re1 != -4 || r.im0 != 4 || r.im1 != 4 || r.k != 1 || r.cyc - last_edge != 3) begin
        errors++;
        $display("FAIL gaps_result got re=%0d,%0d im=%0d,%0d k=%0d lat=%0d want -4,-4 4,4 1 3",
                 r.re0, r.re1, r.im0, r.im1, r.k, r.cyc - last_edge);
      end
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (waddr_q[i] != i) begin errors++; $display("FAIL gaps_waddr[%0d] got %0d want %0d", i, waddr_q[i], i); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load_plan();
    res_q.delete();
    for (int n = 0; n < 2; n++) begin
      valid_i = 1'b1; x[0] = XW'(fx0[n]); x[1] = XW'(fx1[n]); k_i = AW'(1);
      tick();
    end
    valid_i = 1'b0; rst = 1'b1;
    tick();
    vectors++;
    if ({re, im} !== '0 || k_o !== '0 || w_addr !== '0 || {valid_o, finish, overrun, busy} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_zero re=%h im=%h k_o=%0d w_addr=%0d flags=%b want all 0",
               re, im, k_o, w_addr, {valid_o, finish, overrun, busy});
    end
    tick();
    rst = 1'b0;
    send_frame(1, 0, 0);
    wait_results(1, 10);
    repeat (2) tick();
    vectors++;
    if (res_q.size() != 1) begin
      errors++; $display("FAIL rstmid_count got %0d want 1", res_q.size());
    end else begin
      vectors++;
      if (res_q[0].re0 != -4 || res_q[0].re1 != -4 || res_q[0].im0 != 4 || res_q[0].im1 != 4) begin
        errors++;
        $display("FAIL rstmid_result got re=%0d,%0d im=%0d,%0d want -4,-4 4,4",
                 res_q[0].re0, res_q[0].re1, res_q[0].im0, res_q[0].im1);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int          k;
    res_q.delete(); exp_q.delete();
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N; i++) begin
        v = 16'($urandom); rom_re[i] = int'($signed(v));
        v = 16'($urandom); rom_im[i] = int'($signed(v));
        v = 16'($urandom); fx0[i]    = int'($signed(v));
        v = 16'($urandom); fx1[i]    = int'($signed(v));
      end
      k = int'($urandom_range(7, 0));
      exp_q.push_back(expect_for(k));
      send_frame(k, 0, int'($urandom_range(2, 0)));
    end
    wait_results(24, 40);
    vectors++;
    if (res_q.size() != 24) begin
      errors++; $display("FAIL rand_count got %0d want 24", res_q.size());
    end else begin
      for (int f = 0; f < 24; f++) begin
        vectors++;
        if (res_q[f].re0 != exp_q[f].re0 || res_q[f].re1 != exp_q[f].re1 ||
            res_q[f].im0 != exp_q[f].im0 || res_q[f].im1 != exp_q[f].im1 || res_q[f].k != exp_q[f].k) begin
          errors++;
          $display("FAIL rand_frame%0d got re=%0d,%0d im=%0d,%0d k=%0d want re=%0d,%0d im=%0d,%0d k=%0d",
                   f, res_q[f].re0, res_q[f].re1, res_q[f].im0, res_q[f].im1, res_q[f].k,
                   exp_q[f].re0, exp_q[f].re1, exp_q[f].im0, exp_q[f].im1, exp_q[f].k);
        end
      end
    end
  endtask

  initial begin
    load_plan();
    test_reset();
    test_k1();
    test_k_values();
    test_back_to_back();
    test_overrun();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
